// File: rtl/xw_univ_shreg.sv
`default_nettype none
// ============================================================================
//  Module   : xw_univ_shreg
//  Brief    : Parametrised universal shift register with true/complement
//             outputs, eight per-cycle modes and an autonomous burst-shift
//             engine that reports completion with a one-cycle DONE pulse.
//  Revision : 1.0  initial release
// ============================================================================
module xw_univ_shreg #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             CLK,
  input  logic             CLR_L,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SRI,
  input  logic             SLI,
  input  logic             START,
  input  logic [CNTW-1:0]  BCNT,
  input  logic             BDIR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SRO,
  output logic             SLO,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_SET  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;
  logic             dir_q,   dir_d;
  logic             done_q,  done_d;

  // Next-state: a running burst owns the register; otherwise EN gates START,
  // and START takes precedence over the MODE operation in the same cycle.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    if (state_q == S_RUN) begin
      if (EN) begin
        // Burst shifts use the serial inputs, never rotate.
        if (dir_q) q_d = {q_q[WIDTH-2:0], SLI};
        else       q_d = {SRI, q_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNTW'(1);
        // Remaining count of one means this edge performs the final shift,
        // so the counter never wraps below zero.
        if (cnt_q == CNTW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    end else if (EN) begin
      if (START) begin
        cnt_d = BCNT;
        dir_d = BDIR;
        // A zero-length burst completes immediately without raising BUSY.
        if (BCNT != '0) state_d = S_RUN;
        else            done_d  = 1'b1;
      end else begin
        case (MODE)
          M_HOLD:  q_d = q_q;
          M_SHR:   q_d = {SRI, q_q[WIDTH-1:1]};
          M_SHL:   q_d = {q_q[WIDTH-2:0], SLI};
          M_LOAD:  q_d = D;
          M_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
          M_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          M_SET:   q_d = '1;
          M_CLR:   q_d = '0;
          default: q_d = q_q;
        endcase
      end
    end
  end

  // State registers; CLR_L low overrides everything, including EN and a burst.
  always_ff @(posedge CLK) begin
    if (!CLR_L) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign QN   = ~q_q;
  assign SRO  = q_q[0];
  assign SLO  = q_q[WIDTH-1];
  assign BUSY = (state_q == S_RUN);
  assign DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_xw_univ_shreg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xw_univ_shreg
//  Brief    : Self-checking bench for xw_univ_shreg (WIDTH=8, CNTW=4):
//             table of per-cycle mode vectors plus hand-written burst,
//             stall, zero-count, START-masking and mid-burst reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xw_univ_shreg;

  logic       CLK = 1'b0;
  logic       CLR_L, EN, SRI, SLI, START, BDIR;
  logic [2:0] MODE;
  logic [7:0] D;
  logic [3:0] BCNT;
  logic [7:0] Q, QN;
  logic       SRO, SLO, BUSY, DONE;

  int checks   = 0;
  int failures = 0;

  xw_univ_shreg #(.WIDTH(8), .CNTW(4)) dut (
    .CLK(CLK), .CLR_L(CLR_L), .EN(EN), .MODE(MODE), .D(D),
    .SRI(SRI), .SLI(SLI), .START(START), .BCNT(BCNT), .BDIR(BDIR),
    .Q(Q), .QN(QN), .SRO(SRO), .SLO(SLO), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sri;
    logic       sli;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vec [0:13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] eq,
                           input logic eb, input logic ed);
    chk({tag, ".Q"},    {24'd0, Q},  {24'd0, eq});
    chk({tag, ".QN"},   {24'd0, QN}, {24'd0, ~eq});
    chk({tag, ".BUSY"}, {31'd0, BUSY}, {31'd0, eb});
    chk({tag, ".DONE"}, {31'd0, DONE}, {31'd0, ed});
  endtask

  initial begin
    // en mode  d      sri  sli  expected Q
    vec[0]  = '{1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5}; // load
    vec[1]  = '{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'hD2}; // rotate right
    vec[2]  = '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'hA5}; // rotate left
    vec[3]  = '{1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 8'hD2}; // shift right SRI=1
    vec[4]  = '{1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 8'hA4}; // shift left SLI=0
    vec[5]  = '{1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'hFF}; // preset
    vec[6]  = '{1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'h00}; // clear
    vec[7]  = '{1'b0, 3'b011, 8'h3C, 1'b0, 1'b0, 8'h00}; // EN=0 load ignored
    vec[8]  = '{1'b1, 3'b011, 8'h3C, 1'b0, 1'b0, 8'h3C}; // load
    vec[9]  = '{1'b1, 3'b001, 8'h00, 1'b0, 1'b1, 8'h1E}; // shift right SRI=0
    vec[10] = '{1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 8'h3D}; // shift left SLI=1
    vec[11] = '{1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 8'h3D}; // hold
    vec[12] = '{1'b1, 3'b011, 8'h81, 1'b0, 1'b0, 8'h81}; // load
    vec[13] = '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h03}; // rotate left wraps MSB

    CLR_L = 1'b0; EN = 1'b1; MODE = 3'b000; D = 8'h00; SRI = 1'b0; SLI = 1'b0;
    START = 1'b0; BCNT = 4'd0; BDIR = 1'b0;
    step();
    step();
    chk_state("reset0", 8'h00, 1'b0, 1'b0);
    CLR_L = 1'b1;

    // Reset after activity, with EN high and then with EN low.
    MODE = 3'b011; D = 8'h5A; step();
    chk("pre_rst.Q", {24'd0, Q}, 32'h5A);
    CLR_L = 1'b0; step();
    chk_state("rst_en1", 8'h00, 1'b0, 1'b0);
    CLR_L = 1'b1; D = 8'hC3; step();
    EN = 1'b0; CLR_L = 1'b0; step();
    chk_state("rst_en0", 8'h00, 1'b0, 1'b0);
    CLR_L = 1'b1; EN = 1'b1; MODE = 3'b000; step();

    // Table-driven per-cycle modes.
    for (int i = 0; i <= 13; i++) begin
      EN = vec[i].en; MODE = vec[i].mode; D = vec[i].d;
      SRI = vec[i].sri; SLI = vec[i].sli;
      step();
      chk_state($sformatf("vec%0d", i), vec[i].exp_q, 1'b0, 1'b0);
      chk($sformatf("vec%0d.SRO", i), {31'd0, SRO}, {31'd0, vec[i].exp_q[0]});
      chk($sformatf("vec%0d.SLO", i), {31'd0, SLO}, {31'd0, vec[i].exp_q[7]});
    end

    // Burst right by 3 from 0x81; MODE=load held to prove it is masked,
    // and a second START mid-burst must be ignored.
    EN = 1'b1; MODE = 3'b011; D = 8'h81; step();
    D = 8'hFF; START = 1'b1; BCNT = 4'd3; BDIR = 1'b0; SRI = 1'b0; step();
    chk_state("b1_start", 8'h81, 1'b1, 1'b0);
    START = 1'b0; step();
    chk_state("b1_s1", 8'h40, 1'b1, 1'b0);
    chk("b1_s1.SRO", {31'd0, SRO}, 32'd0);
    START = 1'b1; BCNT = 4'd5; BDIR = 1'b1; step();
    chk_state("b1_s2", 8'h20, 1'b1, 1'b0);
    chk("b1_s2.SRO", {31'd0, SRO}, 32'd0);
    START = 1'b0; step();
    chk_state("b1_s3", 8'h10, 1'b0, 1'b1);
    chk("b1_s3.SRO", {31'd0, SRO}, 32'd0);
    MODE = 3'b000; step();
    chk_state("b1_after", 8'h10, 1'b0, 1'b0);

    // Burst left by 2 from 0x01 with two stalled cycles.
    MODE = 3'b011; D = 8'h01; step();
    MODE = 3'b000; START = 1'b1; BCNT = 4'd2; BDIR = 1'b1; SLI = 1'b1; step();
    chk_state("b2_start", 8'h01, 1'b1, 1'b0);
    START = 1'b0; EN = 1'b0; step();
    chk_state("b2_stall1", 8'h01, 1'b1, 1'b0);
    step();
    chk_state("b2_stall2", 8'h01, 1'b1, 1'b0);
    EN = 1'b1; step();
    chk_state("b2_s1", 8'h03, 1'b1, 1'b0);
    step();
    chk_state("b2_s2", 8'h07, 1'b0, 1'b1);
    step();
    chk_state("b2_after", 8'h07, 1'b0, 1'b0);

    // Zero-count burst, then a new START accepted in the DONE cycle.
    START = 1'b1; BCNT = 4'd0; BDIR = 1'b0; step();
    chk_state("b0_done", 8'h07, 1'b0, 1'b1);
    BCNT = 4'd1; SRI = 1'b1; step();
    chk_state("b0_restart", 8'h07, 1'b1, 1'b0);
    START = 1'b0; step();
    chk_state("b0_s1", 8'h83, 1'b0, 1'b1);
    step();
    chk_state("b0_after", 8'h83, 1'b0, 1'b0);

    // START with EN low in IDLE is dropped, not queued.
    EN = 1'b0; START = 1'b1; BCNT = 4'd2; step();
    chk_state("en0_start", 8'h83, 1'b0, 1'b0);
    EN = 1'b1; START = 1'b0; step();
    chk_state("en0_nq", 8'h83, 1'b0, 1'b0);

    // Reset in the middle of a burst aborts it with no DONE.
    MODE = 3'b110; step();
    MODE = 3'b000; START = 1'b1; BCNT = 4'd4; BDIR = 1'b0; SRI = 1'b0; step();
    START = 1'b0; step();
    chk_state("br_s1", 8'h7F, 1'b1, 1'b0);
    CLR_L = 1'b0; step();
    chk_state("br_rst", 8'h00, 1'b0, 1'b0);
    CLR_L = 1'b1; step();
    chk_state("br_after1", 8'h00, 1'b0, 1'b0);
    step();
    chk_state("br_after2", 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
